fetch_unit: RTL and testbench

Instruction-fetch sequencer sitting directly upstream of the address/opcode register stage. Holds the 10-bit program counter and issues single-outstanding read requests to instruction memory. Captures the returned 10-bit word and presents it, with a valid/ready handshake, as the word the opcode register latches. Handles taken branches by redirecting the PC and squashing any in-flight or held word, and stops permanently on a halt opcode.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/pc_counter.sv | 30 +++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package cpu_pkg;
    localparam int              ADDR_W   = 10;
    localparam logic [ADDR_W-1:0] RESET_PC = 10'h000;
    localparam logic [ADDR_W-1:0] HALT_OP  = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/pc_counter.sv
// Program counter: branch load wins over increment; increment wraps at 2^ADDR_W.
import cpu_pkg::*;

module pc_counter (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = load_val_i;
        else if (inc_i)
            pc_d = pc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch sequencer feeding the opcode register
// through a valid/ready hold stage; branches squash, HALT_OP stops for good.
import cpu_pkg::*;

module fetch_unit (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted
);
    fetch_state_t      state_q;
    logic              mem_req_q, ir_valid_q, halted_q;
    logic [ADDR_W-1:0] ir_out_q, ir_pc_q;
    logic [ADDR_W-1:0] pc;
    logic              pc_load, pc_inc;

    // A branch is honoured everywhere except HALT; an ack only advances the
    // PC when it is not being overridden by a branch the same cycle.
    assign pc_load = branch_en && (state_q != HALT);
    assign pc_inc  = (state_q == REQ) && mem_ack && !branch_en;

    pc_counter u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_val_i (branch_target),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b0;
            ir_out_q   <= '0;
            ir_pc_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (branch_en) begin
                        state_q <= REQ;
                    end else if (mem_ack) begin
                        state_q    <= HOLD;
                        mem_req_q  <= 1'b0;
                        ir_valid_q <= 1'b1;
                        ir_out_q   <= mem_rdata;
                        ir_pc_q    <= pc;
                    end
                end
                HOLD: begin
                    // Squash beats consume, so a squashed HALT_OP never halts.
                    if (branch_en) begin
                        state_q    <= REQ;
                        mem_req_q  <= 1'b1;
                        ir_valid_q <= 1'b0;
                    end else if (ir_ready) begin
                        ir_valid_q <= 1'b0;
                        if (ir_out_q == HALT_OP) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = pc;
    assign ir_valid = ir_valid_q;
    assign ir_out   = ir_out_q;
    assign ir_pc    = ir_pc_q;
    assign halted   = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected fetched words.
module tb_fetch_unit;
    logic       clk = 1'b0;
    logic       rst, start, mem_req, mem_ack, ir_valid, ir_ready, branch_en, halted;
    logic [9:0] mem_addr, mem_rdata, ir_out, ir_pc, branch_target;

    logic       auto_ack, man_ack, force_en;
    logic [9:0] force_val;

    int errors = 0;
    int checks = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    // Memory model: optional zero-wait ack, data = addr ^ 10'h155 unless forced.
    assign mem_ack   = auto_ack ? mem_req : man_ack;
    assign mem_rdata = force_en ? force_val : (mem_addr ^ 10'h155);

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .ir_valid      (ir_valid),
        .ir_out        (ir_out),
        .ir_pc         (ir_pc),
        .ir_ready      (ir_ready),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .halted        (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until a word is presented, then pop and compare it.
    task automatic get_word(input string tag, input int max_cyc, input int exp_wait);
        logic [19:0] e;
        int waited;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!ir_valid && waited < max_cyc);
        chk({tag, "_valid"}, {31'd0, ir_valid}, 32'd1);
        if (exp_wait > 0) chk({tag, "_latency"}, waited, exp_wait);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_ir_out"}, {22'd0, ir_out}, {22'd0, e[19:10]});
            chk({tag, "_ir_pc"},  {22'd0, ir_pc},  {22'd0, e[9:0]});
        end
    endtask

    initial begin
        logic [9:0] held_out, held_pc;
        rst = 1'b1; start = 1'b0; ir_ready = 1'b0; branch_en = 1'b0; branch_target = '0;
        auto_ack = 1'b0; man_ack = 1'b0; force_en = 1'b0; force_val = '0;
        step(); step();
        chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_ir_out",   {22'd0, ir_out},   32'd0);
        chk("rst_ir_pc",    {22'd0, ir_pc},    32'd0);
        chk("rst_halted",   {31'd0, halted},   32'd0);
        chk("rst_pc",       {22'd0, mem_addr}, 32'd0);
        rst = 1'b0;

        // Zero-wait streaming, one word every two cycles.
        auto_ack = 1'b1; ir_ready = 1'b1;
        exp_q.push_back({10'h155, 10'd0});
        exp_q.push_back({10'h154, 10'd1});
        exp_q.push_back({10'h157, 10'd2});
        start = 1'b1; step(); start = 1'b0;
        chk("start_req",  {31'd0, mem_req},  32'd1);
        chk("start_addr", {22'd0, mem_addr}, 32'd0);
        get_word("w0", 10, 1);
        get_word("w1", 10, 2);
        get_word("w2", 10, 2);

        // Backpressure in HOLD for 5 cycles.
        step();
        ir_ready = 1'b0;
        exp_q.push_back({10'h156, 10'd3});
        get_word("w3", 10, 1);
        held_out = ir_out; held_pc = ir_pc;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {31'd0, ir_valid}, 32'd1);
            chk("bp_out",   {22'd0, ir_out},   {22'd0, 10'h156});
            chk("bp_pc",    {22'd0, ir_pc},    {22'd0, 10'd3});
            chk("bp_req",   {31'd0, mem_req},  32'd0);
        end
        ir_ready = 1'b1;
        step();
        chk("bp_release_req",  {31'd0, mem_req},  32'd1);
        chk("bp_release_addr", {22'd0, mem_addr}, 32'd4);

        // Branch coinciding with the ack for address 5.
        exp_q.push_back({10'h151, 10'd4});
        get_word("w4", 10, 1);
        step();
        chk("pre_br_addr", {22'd0, mem_addr}, 32'd5);
        branch_en = 1'b1; branch_target = 10'h200;
        step();
        branch_en = 1'b0;
        chk("br_ack_req",    {31'd0, mem_req},  32'd1);
        chk("br_ack_addr",   {22'd0, mem_addr}, {22'd0, 10'h200});
        chk("br_ack_valid",  {31'd0, ir_valid}, 32'd0);
        chk("br_ack_ir_out", {22'd0, ir_out},   {22'd0, 10'h151});
        exp_q.push_back({10'h355, 10'h200});
        get_word("w200", 10, 1);

        // Squash a held HALT_OP with a branch to 3FF, then wrap to 0.
        step();
        force_en = 1'b1; force_val = 10'h3FF;
        exp_q.push_back({10'h3FF, 10'h201});
        get_word("whalt_sq", 10, 1);
        force_en = 1'b0;
        branch_en = 1'b1; branch_target = 10'h3FF;
        step();
        branch_en = 1'b0;
        chk("sq_valid",  {31'd0, ir_valid}, 32'd0);
        chk("sq_halted", {31'd0, halted},   32'd0);
        chk("sq_req",    {31'd0, mem_req},  32'd1);
        chk("sq_addr",   {22'd0, mem_addr}, {22'd0, 10'h3FF});
        exp_q.push_back({10'h2AA, 10'h3FF});
        get_word("w3ff", 10, 1);
        step();
        chk("wrap_req",  {31'd0, mem_req},  32'd1);
        chk("wrap_addr", {22'd0, mem_addr}, 32'd0);

        // Consume HALT_OP fetched from address 3.
        branch_en = 1'b1; branch_target = 10'd3;
        step();
        branch_en = 1'b0;
        chk("br3_addr", {22'd0, mem_addr}, 32'd3);
        force_en = 1'b1; force_val = 10'h3FF;
        exp_q.push_back({10'h3FF, 10'd3});
        get_word("whalt", 10, 1);
        force_en = 1'b0;
        step();
        chk("halt_halted", {31'd0, halted},   32'd1);
        chk("halt_req",    {31'd0, mem_req},  32'd0);
        chk("halt_valid",  {31'd0, ir_valid}, 32'd0);
        start = 1'b1; branch_en = 1'b1; branch_target = 10'h100;
        step();
        start = 1'b0; branch_en = 1'b0;
        step();
        chk("halt_ign_halted", {31'd0, halted},   32'd1);
        chk("halt_ign_req",    {31'd0, mem_req},  32'd0);
        chk("halt_ign_addr",   {22'd0, mem_addr}, 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("unhalt_halted", {31'd0, halted},   32'd0);
        chk("unhalt_pc",     {22'd0, mem_addr}, 32'd0);
        chk("unhalt_req",    {31'd0, mem_req},  32'd0);
        chk("unhalt_valid",  {31'd0, ir_valid}, 32'd0);

        // IDLE branch alone, then branch together with start.
        auto_ack = 1'b0;
        step();
        chk("idle_req", {31'd0, mem_req}, 32'd0);
        branch_en = 1'b1; branch_target = 10'h020;
        step();
        branch_en = 1'b0;
        chk("idle_br_req",  {31'd0, mem_req},  32'd0);
        chk("idle_br_addr", {22'd0, mem_addr}, {22'd0, 10'h020});
        start = 1'b1; branch_en = 1'b1; branch_target = 10'h030;
        step();
        start = 1'b0; branch_en = 1'b0;
        chk("idle_sbr_req",  {31'd0, mem_req},  32'd1);
        chk("idle_sbr_addr", {22'd0, mem_addr}, {22'd0, 10'h030});

        // Branch in REQ without ack, then reset during a slow access.
        branch_en = 1'b1; branch_target = 10'h050;
        step();
        branch_en = 1'b0;
        chk("req_br_req",  {31'd0, mem_req},  32'd1);
        chk("req_br_addr", {22'd0, mem_addr}, {22'd0, 10'h050});
        step(); step();
        chk("slow_req",   {31'd0, mem_req},  32'd1);
        chk("slow_valid", {31'd0, ir_valid}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        chk("late_ack_valid", {31'd0, ir_valid}, 32'd0);
        chk("late_ack_req",   {31'd0, mem_req},  32'd0);
        chk("late_ack_out",   {22'd0, ir_out},   32'd0);
        step();
        chk("late_ack_valid2", {31'd0, ir_valid}, 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
